fft_bitrev_reorder: RTL and testbench

- Output-end reorder buffer for the pipelined DIF FFT.
- The last DIF stage emits frames of N = 2**TOTAL_STAGES complex samples in bit-reversed bin order. This block writes each frame into a ping-pong RAM at bit-reversed addresses and reads it back in natural bin order (0..N-1) as a contiguous burst.
- It accepts gapped input (i_vld may drop at any time) and produces gap-free output frames.

---
 rtl/fft_bitrev_reorder.sv | 173 +++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder
// Function : Ping-pong reorder buffer turning bit-reversed DIF FFT frames into
//            gap-free natural-order output bursts.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder #(
  parameter int   IN_W         = 11,
  parameter int   TOTAL_STAGES = 8,
  parameter logic BIT_REV      = 1'b1
) (
  input  logic                   mclk,
  input  logic                   i_init,
  input  logic                   i_vld,
  input  logic signed [IN_W-1:0] i_I,
  input  logic signed [IN_W-1:0] i_Q,
  output logic                   o_vld,
  output logic signed [IN_W-1:0] o_I,
  output logic signed [IN_W-1:0] o_Q,
  output logic                   o_sof,
  output logic                   o_overflow_strb
);

  localparam int              c_n  = 1 << TOTAL_STAGES;
  localparam int              c_aw = TOTAL_STAGES;
  localparam logic [c_aw-1:0] c_last = '1;

  localparam logic [1:0] c_empty   = 2'd0;
  localparam logic [1:0] c_filling = 2'd1;
  localparam logic [1:0] c_full    = 2'd2;
  localparam logic [1:0] c_reading = 2'd3;

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_read = 1'b1;

  logic [2*IN_W-1:0] r_mem [2*c_n];
  logic [1:0]        r_bank_st  [2];
  logic [1:0]        w_bank_nxt [2];

  logic [c_aw-1:0]   r_widx;
  logic [c_aw-1:0]   w_waddr;
  logic              r_wbank;
  logic              w_wr_ok;
  logic              w_wr_en;
  logic              w_ovf;

  logic [0:0]        r_rd_state;
  logic [0:0]        w_rd_state_nxt;
  logic              r_rbank;
  logic              w_rbank_nxt;
  logic [c_aw-1:0]   r_rd_idx;
  logic [c_aw-1:0]   w_rd_idx_nxt;
  logic [c_aw-1:0]   w_issue_idx;
  logic              w_issue;

  logic              r_ra_en;
  logic              r_ra_sof;
  logic [c_aw:0]     r_ra_addr;
  logic              r_rd_en;
  logic              r_rd_sof;
  logic [2*IN_W-1:0] r_rd_data;

  function automatic logic [c_aw-1:0] f_bitrev(input logic [c_aw-1:0] a);
    for (int i = 0; i < c_aw; i++) f_bitrev[i] = a[c_aw-1-i];
  endfunction

  generate
    if (BIT_REV) begin : g_bitrev
      assign w_waddr = f_bitrev(r_widx);
    end else begin : g_natural
      assign w_waddr = r_widx;
    end
  endgenerate

  assign w_wr_ok = (r_bank_st[r_wbank] == c_empty) || (r_bank_st[r_wbank] == c_filling);
  assign w_wr_en = i_vld && !i_init && w_wr_ok;
  assign w_ovf   = i_vld && !i_init && !w_wr_ok;

  // Writer only touches EMPTY/FILLING banks and the reader only FULL/READING
  // ones, so both sides can update the bank states without colliding.
  // The reader issues bin 0 on the same edge it sees FULL so a bank is
  // released before the writer wraps back onto it at full input rate.
  always_comb begin
    w_bank_nxt[0]  = r_bank_st[0];
    w_bank_nxt[1]  = r_bank_st[1];
    w_rd_state_nxt = r_rd_state;
    w_rbank_nxt    = r_rbank;
    w_rd_idx_nxt   = r_rd_idx;
    w_issue        = 1'b0;
    w_issue_idx    = r_rd_idx;

    if (w_wr_en) w_bank_nxt[r_wbank] = (r_widx == c_last) ? c_full : c_filling;

    if (r_rd_state == c_idle) begin
      if (r_bank_st[r_rbank] == c_full) begin
        w_issue             = 1'b1;
        w_issue_idx         = '0;
        w_bank_nxt[r_rbank] = c_reading;
      end
    end else begin
      w_issue = 1'b1;
    end

    if (w_issue) begin
      if (w_issue_idx == c_last) begin
        w_bank_nxt[r_rbank] = c_empty;
        w_rbank_nxt         = ~r_rbank;
        if (r_bank_st[~r_rbank] == c_full) begin
          w_bank_nxt[~r_rbank] = c_reading;
          w_rd_state_nxt       = c_read;
          w_rd_idx_nxt         = '0;
        end else begin
          w_rd_state_nxt = c_idle;
        end
      end else begin
        w_rd_state_nxt = c_read;
        w_rd_idx_nxt   = w_issue_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (w_wr_en) r_mem[{r_wbank, w_waddr}] <= {i_I, i_Q};
    if (r_ra_en) r_rd_data <= r_mem[r_ra_addr];
  end

  always_ff @(posedge mclk) begin
    if (i_init) begin
      r_bank_st[0]    <= c_empty;
      r_bank_st[1]    <= c_empty;
      r_widx          <= '0;
      r_wbank         <= 1'b0;
      r_rd_state      <= c_idle;
      r_rbank         <= 1'b0;
      r_rd_idx        <= '0;
      r_ra_en         <= 1'b0;
      r_ra_sof        <= 1'b0;
      r_ra_addr       <= '0;
      r_rd_en         <= 1'b0;
      r_rd_sof        <= 1'b0;
      o_vld           <= 1'b0;
      o_sof           <= 1'b0;
      o_I             <= '0;
      o_Q             <= '0;
      o_overflow_strb <= 1'b0;
    end else begin
      r_bank_st[0] <= w_bank_nxt[0];
      r_bank_st[1] <= w_bank_nxt[1];
      if (w_wr_en) begin
        r_widx <= r_widx + 1'b1;
        if (r_widx == c_last) r_wbank <= ~r_wbank;
      end
      r_rd_state <= w_rd_state_nxt;
      r_rbank    <= w_rbank_nxt;
      r_rd_idx   <= w_rd_idx_nxt;
      r_ra_en    <= w_issue;
      r_ra_sof   <= w_issue && (w_issue_idx == '0);
      r_ra_addr  <= {r_rbank, w_issue_idx};
      r_rd_en    <= r_ra_en;
      r_rd_sof   <= r_ra_sof;
      o_vld      <= r_rd_en;
      o_sof      <= r_rd_sof;
      if (r_rd_en) begin
        o_I <= r_rd_data[2*IN_W-1:IN_W];
        o_Q <= r_rd_data[IN_W-1:0];
      end
      o_overflow_strb <= w_ovf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bitrev_reorder
// Function : Scoreboard bench for fft_bitrev_reorder (N=8 reorder, N=8 bypass,
//            N=256 reorder).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_reorder;

  localparam int W = 11;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic init = 1'b1;
  logic a_vld = 1'b0, b_vld = 1'b0, c_vld = 1'b0;
  logic signed [W-1:0] a_i = '0, a_q = '0, b_i = '0, b_q = '0, c_i = '0, c_q = '0;
  logic ao_vld, ao_sof, ao_ovf, bo_vld, bo_sof, bo_ovf, co_vld, co_sof, co_ovf;
  logic signed [W-1:0] ao_i, ao_q, bo_i, bo_q, co_i, co_q;

  fft_bitrev_reorder #(.IN_W(W), .TOTAL_STAGES(3), .BIT_REV(1'b1)) u_a (
    .mclk(mclk), .i_init(init), .i_vld(a_vld), .i_I(a_i), .i_Q(a_q),
    .o_vld(ao_vld), .o_I(ao_i), .o_Q(ao_q), .o_sof(ao_sof), .o_overflow_strb(ao_ovf));

  fft_bitrev_reorder #(.IN_W(W), .TOTAL_STAGES(3), .BIT_REV(1'b0)) u_b (
    .mclk(mclk), .i_init(init), .i_vld(b_vld), .i_I(b_i), .i_Q(b_q),
    .o_vld(bo_vld), .o_I(bo_i), .o_Q(bo_q), .o_sof(bo_sof), .o_overflow_strb(bo_ovf));

  fft_bitrev_reorder #(.IN_W(W), .TOTAL_STAGES(8), .BIT_REV(1'b1)) u_c (
    .mclk(mclk), .i_init(init), .i_vld(c_vld), .i_I(c_i), .i_Q(c_q),
    .o_vld(co_vld), .o_I(co_i), .o_Q(co_q), .o_sof(co_sof), .o_overflow_strb(co_ovf));

  logic [31:0] qa[$], qb[$], qc[$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, t_last = 0, sof_cyc_a = 0;
  int pos_a = 0, pos_b = 0, pos_c = 0;
  bit ovf_a = 0, ovf_b = 0, ovf_c = 0;
  int tbl [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int xi [256], xq [256];

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] mk(input bit s, input int i, input int q);
    mk = {9'd0, s, W'(i), W'(q)};
  endfunction

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // Monitors: pop the expected word whenever a DUT presents output.
  always @(negedge mclk) begin
    if (init) pos_a = 0;
    else if (ao_vld) begin
      if (qa.size() == 0) begin
        n_chk++; $display("FAIL a_unexpected: got o_I=%0d expected no output", ao_i);
      end else check("a_out", {9'd0, ao_sof, ao_i, ao_q}, qa.pop_front());
      if (ao_sof) sof_cyc_a = cyc;
      pos_a = (pos_a + 1) % 8;
    end else if (pos_a != 0) begin
      n_chk++; $display("FAIL a_gap: got o_vld=0 expected 1 at bin %0d", pos_a); pos_a = 0;
    end
    if (ao_ovf) ovf_a = 1;
  end

  always @(negedge mclk) begin
    if (init) pos_b = 0;
    else if (bo_vld) begin
      if (qb.size() == 0) begin
        n_chk++; $display("FAIL b_unexpected: got o_I=%0d expected no output", bo_i);
      end else check("b_out", {9'd0, bo_sof, bo_i, bo_q}, qb.pop_front());
      pos_b = (pos_b + 1) % 8;
    end else if (pos_b != 0) begin
      n_chk++; $display("FAIL b_gap: got o_vld=0 expected 1 at bin %0d", pos_b); pos_b = 0;
    end
    if (bo_ovf) ovf_b = 1;
  end

  always @(negedge mclk) begin
    if (init) pos_c = 0;
    else if (co_vld) begin
      if (qc.size() == 0) begin
        n_chk++; $display("FAIL c_unexpected: got o_I=%0d expected no output", co_i);
      end else check("c_out", {9'd0, co_sof, co_i, co_q}, qc.pop_front());
      pos_c = (pos_c + 1) % 256;
    end else if (pos_c != 0) begin
      n_chk++; $display("FAIL c_gap: got o_vld=0 expected 1 at bin %0d", pos_c); pos_c = 0;
    end
    if (co_ovf) ovf_c = 1;
  end

  task automatic send(input int u, input bit v, input int iv, input int qv);
    case (u)
      0: begin a_vld = v; a_i = W'(iv); a_q = W'(qv); end
      1: begin b_vld = v; b_i = W'(iv); b_q = W'(qv); end
      default: begin c_vld = v; c_i = W'(iv); c_q = W'(qv); end
    endcase
    @(posedge mclk); #1;
    if (v) t_last = cyc;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && k < 600) begin
      @(posedge mclk); k++;
    end
    #1;
    check("drain", qa.size() + qb.size() + qc.size(), 0);
    repeat (4) @(posedge mclk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge mclk);
    #1;
    init = 1'b0;
    check("rst_vld", ao_vld, 0);
    check("rst_sof", ao_sof, 0);
    check("rst_ovf", ao_ovf, 0);
    check("rst_I", ao_i, 0);
    check("rst_Q", ao_q, 0);
    repeat (2) @(posedge mclk);
    #1;

    // Natural reorder plus latency
    for (int n = 0; n < 8; n++) qa.push_back(mk(n == 0, n, -n));
    for (int k = 0; k < 8; k++) send(0, 1, tbl[k], -tbl[k]);
    drain();
    check("latency_cont", sof_cyc_a - t_last, 3);

    // Gapped input
    for (int n = 0; n < 8; n++) qa.push_back(mk(n == 0, n, -n));
    for (int k = 0; k < 8; k++) begin
      send(0, 1, tbl[k], -tbl[k]);
      send(0, 0, 99, 99);
    end
    drain();
    check("latency_gap", sof_cyc_a - t_last, 3);

    // Four back-to-back frames
    for (int n = 0; n < 32; n++) qa.push_back(mk((n % 8) == 0, n, -n));
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 8; k++) send(0, 1, 8 * f + tbl[k], -(8 * f + tbl[k]));
    drain();
    check("a_ovf_none", ovf_a, 0);

    // Reset after a partial frame, then again mid-burst
    for (int k = 0; k < 5; k++) send(0, 1, 100 + tbl[k], 0);
    init = 1'b1;
    @(posedge mclk); #1;
    check("rst_partial_vld", ao_vld, 0);
    @(posedge mclk); #1;
    init = 1'b0;
    for (int n = 0; n < 8; n++) qa.push_back(mk(n == 0, 8 + n, -(8 + n)));
    for (int k = 0; k < 8; k++) send(0, 1, 8 + tbl[k], -(8 + tbl[k]));
    begin
      int k = 0;
      while (qa.size() > 5 && k < 50) begin @(posedge mclk); k++; end
      #1;
      check("burst_started", (qa.size() <= 5) ? 1 : 0, 1);
    end
    init = 1'b1;
    @(posedge mclk); #1;
    check("rst_burst_vld", ao_vld, 0);
    qa.delete();
    @(posedge mclk); #1;
    init = 1'b0;
    for (int n = 0; n < 8; n++) qa.push_back(mk(n == 0, 16 + n, -(16 + n)));
    for (int k = 0; k < 8; k++) send(0, 1, 16 + tbl[k], -(16 + tbl[k]));
    drain();
    check("a_ovf_after_rst", ovf_a, 0);

    // Bypass order
    for (int n = 0; n < 8; n++) qb.push_back(mk(n == 0, n, 3 * n));
    for (int k = 0; k < 8; k++) send(1, 1, k, 3 * k);
    drain();
    check("b_ovf_none", ovf_b, 0);

    // Default size, random data
    for (int n = 0; n < 256; n++) begin
      xi[n] = int'($urandom_range(0, 2047)) - 1024;
      xq[n] = int'($urandom_range(0, 2047)) - 1024;
    end
    xi[0] = -1024; xi[255] = 1023;
    for (int n = 0; n < 256; n++) qc.push_back(mk(n == 0, xi[n], xq[n]));
    for (int k = 0; k < 256; k++) send(2, 1, xi[brev(k, 8)], xq[brev(k, 8)]);
    drain();
    check("c_ovf_none", ovf_c, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
